// File: rtl/dual_issue_scoreboard.sv
// dual_issue_scoreboard
//   Issue scheduler for the even/odd execution pipes. Holds one decoded
//   instruction pair, tracks per-register result latency in a scoreboard and
//   decides each cycle whether to dual-issue, issue even only, or stall.
//   A low issue_* strobe makes the downstream wrapper inject a NOP into that pipe.
//
// Ports
//   clk, rst                 clock (rising edge), async reset (active-low)
//   in_valid / in_ready      pair handshake from ID
//   even_* / odd_*           per-slot decoded fields (vld, reg_wr, dst, latency,
//                            ra/rb/rc, src_used[2:0] = {rc,rb,ra})
//   flush                    branch taken: drop held and incoming pair
//   issue_even, issue_odd    slot leaves to its pipe this cycle
//   stall                    hold non-empty and nothing issued this cycle
//
// Build option
//   ISSUE_STATS_EN  adds stat_dual / stat_single / stat_stall saturating
//                   counters (STAT_W bits), cleared only by rst.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_EMPTY  | nothing pending
// S_PAIR   | even pending (odd pending when odd_pend_q is set)
// S_ODD_ONLY | even already issued, odd still pending

module dual_issue_scoreboard #(
  parameter int NUM_REGS = 128,
  parameter int ADDR_W   = 7,
  parameter int LAT_W    = 4
`ifdef ISSUE_STATS_EN
  , parameter int STAT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              even_vld,
  input  logic              even_reg_wr,
  input  logic [ADDR_W-1:0] even_dst,
  input  logic [LAT_W-1:0]  even_latency,
  input  logic [ADDR_W-1:0] even_ra,
  input  logic [ADDR_W-1:0] even_rb,
  input  logic [ADDR_W-1:0] even_rc,
  input  logic [2:0]        even_src_used,
  input  logic              odd_vld,
  input  logic              odd_reg_wr,
  input  logic [ADDR_W-1:0] odd_dst,
  input  logic [LAT_W-1:0]  odd_latency,
  input  logic [ADDR_W-1:0] odd_ra,
  input  logic [ADDR_W-1:0] odd_rb,
  input  logic [ADDR_W-1:0] odd_rc,
  input  logic [2:0]        odd_src_used,
  input  logic              flush,
  output logic              issue_even,
  output logic              issue_odd,
  output logic              stall
`ifdef ISSUE_STATS_EN
  , output logic [STAT_W-1:0] stat_dual
  , output logic [STAT_W-1:0] stat_single
  , output logic [STAT_W-1:0] stat_stall
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY    = 2'd0,
    S_PAIR     = 2'd1,
    S_ODD_ONLY = 2'd2
  } state_t;

  typedef struct packed {
    logic              reg_wr;
    logic [ADDR_W-1:0] dst;
    logic [LAT_W-1:0]  lat;
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] rb;
    logic [ADDR_W-1:0] rc;
    logic [2:0]        used;
  } slot_t;

  state_t           state_q, state_d;
  logic             odd_pend_q, odd_pend_d;
  slot_t            hold_even_q, hold_odd_q;
  slot_t            in_even, in_odd;
  logic [LAT_W-1:0] sb_cnt [NUM_REGS];
  logic             rst_released_q;

  logic even_pend;
  logic haz_even, haz_odd;
  logic raw_eo, waw_eo;
  logic accept;
  logic set_even, set_odd;

  assign in_even = {even_reg_wr, even_dst, even_latency, even_ra, even_rb, even_rc, even_src_used};
  assign in_odd  = {odd_reg_wr, odd_dst, odd_latency, odd_ra, odd_rb, odd_rc, odd_src_used};

  assign even_pend = (state_q == S_PAIR);

  // A source is a hazard while its result is still in flight.
  always_comb begin
    haz_even = (hold_even_q.used[0] && sb_cnt[hold_even_q.ra] != '0) ||
               (hold_even_q.used[1] && sb_cnt[hold_even_q.rb] != '0) ||
               (hold_even_q.used[2] && sb_cnt[hold_even_q.rc] != '0);
    haz_odd  = (hold_odd_q.used[0] && sb_cnt[hold_odd_q.ra] != '0) ||
               (hold_odd_q.used[1] && sb_cnt[hold_odd_q.rb] != '0) ||
               (hold_odd_q.used[2] && sb_cnt[hold_odd_q.rc] != '0);
  end

  // Intra-pair dependencies are invisible to the scoreboard until even issues.
  always_comb begin
    raw_eo = hold_even_q.reg_wr &&
             ((hold_odd_q.used[0] && hold_odd_q.ra == hold_even_q.dst) ||
              (hold_odd_q.used[1] && hold_odd_q.rb == hold_even_q.dst) ||
              (hold_odd_q.used[2] && hold_odd_q.rc == hold_even_q.dst));
    waw_eo = hold_even_q.reg_wr && hold_odd_q.reg_wr && (hold_even_q.dst == hold_odd_q.dst);
  end

  always_comb begin
    issue_even = !flush && even_pend && !haz_even;
    issue_odd  = !flush && odd_pend_q && !haz_odd &&
                 (issue_even || !even_pend) &&
                 !(issue_even && (raw_eo || waw_eo));
    stall      = !flush && (state_q != S_EMPTY) && !issue_even && !issue_odd;
    in_ready   = rst_released_q && !flush &&
                 ((state_q == S_EMPTY) ||
                  ((!even_pend || issue_even) && (!odd_pend_q || issue_odd)));
  end

  assign accept   = in_valid && in_ready;
  assign set_even = issue_even && hold_even_q.reg_wr;
  assign set_odd  = issue_odd && hold_odd_q.reg_wr;

  always_comb begin
    state_d    = state_q;
    odd_pend_d = odd_pend_q;
    if (flush) begin
      state_d    = S_EMPTY;
      odd_pend_d = 1'b0;
    end else if (accept) begin
      odd_pend_d = odd_vld;
      if (even_vld)     state_d = S_PAIR;
      else if (odd_vld) state_d = S_ODD_ONLY;
      else              state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_PAIR: begin
          if (issue_even) begin
            if (!odd_pend_q || issue_odd) begin
              state_d    = S_EMPTY;
              odd_pend_d = 1'b0;
            end else begin
              state_d = S_ODD_ONLY;
            end
          end
        end
        S_ODD_ONLY: begin
          if (issue_odd) begin
            state_d    = S_EMPTY;
            odd_pend_d = 1'b0;
          end
        end
        default: begin
          state_d    = S_EMPTY;
          odd_pend_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_EMPTY;
      odd_pend_q     <= 1'b0;
      hold_even_q    <= '0;
      hold_odd_q     <= '0;
      rst_released_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      odd_pend_q     <= odd_pend_d;
      rst_released_q <= 1'b1;
      if (flush) begin
        hold_even_q <= '0;
        hold_odd_q  <= '0;
      end else if (accept) begin
        hold_even_q <= in_even;
        hold_odd_q  <= in_odd;
      end
    end
  end

  // Issue-time set wins over the per-cycle decrement; flush leaves counters
  // alone because already-issued results still write back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) sb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (set_even && hold_even_q.dst == ADDR_W'(i))
          sb_cnt[i] <= hold_even_q.lat;
        else if (set_odd && hold_odd_q.dst == ADDR_W'(i))
          sb_cnt[i] <= hold_odd_q.lat;
        else if (sb_cnt[i] != '0)
          sb_cnt[i] <= sb_cnt[i] - {{(LAT_W-1){1'b0}}, 1'b1};
      end
    end
  end

`ifdef ISSUE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_dual   <= '0;
      stat_single <= '0;
      stat_stall  <= '0;
    end else begin
      if (issue_even && issue_odd && stat_dual != '1)
        stat_dual <= stat_dual + STAT_W'(1);
      if ((issue_even ^ issue_odd) && stat_single != '1)
        stat_single <= stat_single + STAT_W'(1);
      if (stall && stat_stall != '1)
        stat_stall <= stat_stall + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_dual_issue_scoreboard.sv
module tb_dual_issue_scoreboard;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       flush = 1'b0;
  logic       even_vld, even_reg_wr;
  logic [6:0] even_dst, even_ra, even_rb, even_rc;
  logic [3:0] even_latency;
  logic [2:0] even_src_used;
  logic       odd_vld, odd_reg_wr;
  logic [6:0] odd_dst, odd_ra, odd_rb, odd_rc;
  logic [3:0] odd_latency;
  logic [2:0] odd_src_used;
  logic       issue_even, issue_odd, stall;
`ifdef ISSUE_STATS_EN
  logic [31:0] stat_dual, stat_single, stat_stall;
`endif

  int total = 0;
  int bad   = 0;
  int n;

  dual_issue_scoreboard dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .even_vld(even_vld), .even_reg_wr(even_reg_wr), .even_dst(even_dst),
    .even_latency(even_latency), .even_ra(even_ra), .even_rb(even_rb),
    .even_rc(even_rc), .even_src_used(even_src_used),
    .odd_vld(odd_vld), .odd_reg_wr(odd_reg_wr), .odd_dst(odd_dst),
    .odd_latency(odd_latency), .odd_ra(odd_ra), .odd_rb(odd_rb),
    .odd_rc(odd_rc), .odd_src_used(odd_src_used),
    .flush(flush), .issue_even(issue_even), .issue_odd(issue_odd), .stall(stall)
`ifdef ISSUE_STATS_EN
    , .stat_dual(stat_dual), .stat_single(stat_single), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_even(input int v, input int wr, input int dst, input int lat,
                          input int ra, input int rb, input int rc, input int used);
    even_vld      = v[0];
    even_reg_wr   = wr[0];
    even_dst      = dst[6:0];
    even_latency  = lat[3:0];
    even_ra       = ra[6:0];
    even_rb       = rb[6:0];
    even_rc       = rc[6:0];
    even_src_used = used[2:0];
  endtask

  task automatic set_odd(input int v, input int wr, input int dst, input int lat,
                         input int ra, input int rb, input int rc, input int used);
    odd_vld      = v[0];
    odd_reg_wr   = wr[0];
    odd_dst      = dst[6:0];
    odd_latency  = lat[3:0];
    odd_ra       = ra[6:0];
    odd_rb       = rb[6:0];
    odd_rc       = rc[6:0];
    odd_src_used = used[2:0];
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    repeat (cycles) tick();
  endtask

  // Counts stall cycles until either slot issues; leaves the bench in the issuing cycle.
  task automatic count_stalls(input string tag, output int cnt);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (issue_even || issue_odd) break;
      if (stall) cnt++;
      tick();
    end
    if (!(issue_even || issue_odd))
      check_eq({tag, "_timeout"}, int'(issue_even | issue_odd), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_even(0, 0, 0, 0, 0, 0, 0, 0);
    set_odd(0, 0, 0, 0, 0, 0, 0, 0);

    // reset state
    tick();
    check_eq("rst_issue_even", int'(issue_even), 0);
    check_eq("rst_issue_odd", int'(issue_odd), 0);
    check_eq("rst_stall", int'(stall), 0);
    check_eq("rst_in_ready", int'(in_ready), 0);
    rst = 1'b1;
    tick();
    check_eq("rst_release_ready", int'(in_ready), 1);

    // 1: independent pair, both issue one cycle after accept
    set_even(1, 1, 3, 2, 1, 2, 0, 3);
    set_odd(1, 1, 4, 6, 5, 0, 0, 1);
    in_valid = 1'b1;
    check_eq("t1_ready_empty", int'(in_ready), 1);
    check_eq("t1_no_issue_empty", int'(issue_even), 0);
    tick();
    check_eq("t1_issue_even", int'(issue_even), 1);
    check_eq("t1_issue_odd", int'(issue_odd), 1);
    check_eq("t1_ready", int'(in_ready), 1);
    check_eq("t1_stall", int'(stall), 0);
    // back-to-back readers of r3 (lat 2) and r4 (lat 6)
    set_even(1, 0, 0, 0, 3, 0, 0, 1);
    set_odd(1, 0, 0, 0, 4, 0, 0, 1);
    tick();
    in_valid = 1'b0;
    count_stalls("t1_r3", n);
    check_eq("t1_r3_stalls", n, 2);
    check_eq("t1_r3_odd_held", int'(issue_odd), 0);
    tick();
    count_stalls("t1_r4", n);
    check_eq("t1_r4_stalls", n, 3);
    check_eq("t1_r4_odd_issue", int'(issue_odd), 1);

    // 2: even writes r10 lat 6, next even reads r10
    idle(2);
    set_even(1, 1, 10, 6, 0, 0, 0, 0);
    set_odd(0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b1;
    tick();
    check_eq("t2_issue_even", int'(issue_even), 1);
    check_eq("t2_issue_odd_empty", int'(issue_odd), 0);
    check_eq("t2_ready", int'(in_ready), 1);
    set_even(1, 0, 0, 0, 10, 0, 0, 1);
    tick();
    in_valid = 1'b0;
    count_stalls("t2", n);
    check_eq("t2_stalls", n, 6);
    check_eq("t2_issue_after", int'(issue_even), 1);

    // 3: odd reads even's destination r7 (lat 3)
    idle(2);
    set_even(1, 1, 7, 3, 0, 0, 0, 0);
    set_odd(1, 0, 0, 0, 0, 7, 0, 2);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("t3_issue_even", int'(issue_even), 1);
    check_eq("t3_odd_raw_block", int'(issue_odd), 0);
    check_eq("t3_stall", int'(stall), 0);
    check_eq("t3_ready", int'(in_ready), 0);
    tick();
    count_stalls("t3", n);
    check_eq("t3_odd_stalls", n, 3);
    check_eq("t3_odd_issue", int'(issue_odd), 1);

    // 4: both write r9 (even lat 5, odd lat 2); odd value must win
    idle(2);
    set_even(1, 1, 9, 5, 0, 0, 0, 0);
    set_odd(1, 1, 9, 2, 0, 0, 0, 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("t4_issue_even", int'(issue_even), 1);
    check_eq("t4_odd_waw_block", int'(issue_odd), 0);
    tick();
    check_eq("t4_odd_issue", int'(issue_odd), 1);
    check_eq("t4_even_idle", int'(issue_even), 0);
    check_eq("t4_ready", int'(in_ready), 1);
    set_even(1, 0, 0, 0, 9, 0, 0, 1);
    set_odd(0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    count_stalls("t4", n);
    check_eq("t4_r9_stalls", n, 2);

    // 5: flush in ODD_ONLY with an incoming pair
    idle(2);
    set_even(1, 1, 12, 4, 0, 0, 0, 0);
    set_odd(1, 0, 0, 0, 12, 0, 0, 1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("t5_issue_even", int'(issue_even), 1);
    tick();
    check_eq("t5_odd_stall", int'(stall), 1);
    flush = 1'b1;
    in_valid = 1'b1;
    set_even(1, 1, 13, 1, 0, 0, 0, 0);
    set_odd(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_eq("t5_flush_ie", int'(issue_even), 0);
    check_eq("t5_flush_io", int'(issue_odd), 0);
    check_eq("t5_flush_ready", int'(in_ready), 0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    check_eq("t5_after_stall", int'(stall), 0);
    check_eq("t5_after_ie", int'(issue_even), 0);
    check_eq("t5_after_io", int'(issue_odd), 0);
    check_eq("t5_after_ready", int'(in_ready), 1);
    set_even(1, 0, 0, 0, 12, 0, 0, 1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    count_stalls("t5", n);
    check_eq("t5_r12_stalls", n, 2);

    // 6: reset in the middle of a stall on r10
    idle(2);
    set_even(1, 1, 10, 5, 0, 0, 0, 0);
    set_odd(0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b1;
    tick();
    set_even(1, 0, 0, 0, 10, 0, 0, 1);
    tick();
    in_valid = 1'b0;
    tick();
    check_eq("t6_pre_stall", int'(stall), 1);
    rst = 1'b0;
    #1;
    check_eq("t6_rst_ie", int'(issue_even), 0);
    check_eq("t6_rst_io", int'(issue_odd), 0);
    check_eq("t6_rst_stall", int'(stall), 0);
    check_eq("t6_rst_ready", int'(in_ready), 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_eq("t6_release_ready", int'(in_ready), 1);
    set_even(1, 0, 0, 0, 10, 0, 0, 1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("t6_reader_issue", int'(issue_even), 1);
    check_eq("t6_reader_stall", int'(stall), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
